// File: rtl/axi_log_arbiter.sv
// axi_log_arbiter
// Collects completed AR/AW handshake events from NUM_REQ address-channel
// monitors into small per-requester FIFOs and drains them round-robin, one
// entry per cycle, into a single BRAM logger trigger/data port. Also
// sequences logger clear/ready/full status and counts events lost to
// FIFO overflow.
module axi_log_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned REQ_DATA_BITW = 48,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned SRC_BITW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              Clk_CI,
  input  logic                              Rst_RBI,
  input  logic [NUM_REQ-1:0]                ReqEvent_SI,
  input  logic [NUM_REQ*REQ_DATA_BITW-1:0]  ReqData_DI,
  input  logic                              LogEn_SI,
  input  logic                              Clear_SI,
  input  logic                              LoggerReady_SI,
  input  logic                              LoggerFull_SI,
  output logic                              LogTrigger_SO,
  output logic [REQ_DATA_BITW+SRC_BITW-1:0] LogData_DO,
  output logic [15:0]                       DropCnt_DO,
  output logic                              Overflow_SO,
  output logic                              Busy_SO
);

  localparam int unsigned IDX_BITW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PTR_BITW = IDX_BITW + 1;
  localparam int unsigned OUT_BITW = REQ_DATA_BITW + SRC_BITW;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Number of set bits in a per-requester event vector.
  function automatic logic [SRC_BITW:0] popcount(input logic [NUM_REQ-1:0] vec);
    logic [SRC_BITW:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = cnt + (SRC_BITW+1)'(vec[i]);
    end
    return cnt;
  endfunction

  state_e                    state_q, state_d;
  logic [SRC_BITW-1:0]       rr_q, rr_d;
  logic [PTR_BITW-1:0]       wr_ptr_q [NUM_REQ];
  logic [PTR_BITW-1:0]       wr_ptr_d [NUM_REQ];
  logic [PTR_BITW-1:0]       rd_ptr_q [NUM_REQ];
  logic [PTR_BITW-1:0]       rd_ptr_d [NUM_REQ];
  logic [REQ_DATA_BITW-1:0]  fifo_mem_q [NUM_REQ][FIFO_DEPTH];
  logic                      trig_q, trig_d;
  logic [OUT_BITW-1:0]       data_q, data_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      busy_q, busy_d;

  logic [NUM_REQ-1:0]        empty_s;
  logic [NUM_REQ-1:0]        full_s;
  logic [NUM_REQ-1:0]        push_s;
  logic [NUM_REQ-1:0]        pop_s;
  logic [NUM_REQ-1:0]        drop_s;
  logic                      gnt_valid_s;
  logic [SRC_BITW-1:0]       gnt_idx_s;
  logic                      hold_clear_s;
  logic                      accept_s;

  // A pending clear or the CLEAR state keeps every FIFO and the RR pointer at zero.
  assign hold_clear_s = Clear_SI || (state_q == ST_CLEAR);
  // Events are only taken in RUN/HALT while logging is enabled.
  assign accept_s     = LogEn_SI && !hold_clear_s;

  // FIFO status: equal pointers = empty, differing only in the wrap bit = full.
  always_comb begin
    empty_s = '0;
    full_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      empty_s[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_s[i]  = (wr_ptr_q[i][PTR_BITW-1] != rd_ptr_q[i][PTR_BITW-1]) &&
                   (wr_ptr_q[i][IDX_BITW-1:0] == rd_ptr_q[i][IDX_BITW-1:0]);
    end
  end

  // Round-robin grant: first non-empty FIFO at or after the RR pointer.
  always_comb begin
    logic [SRC_BITW:0] cand;
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    cand        = '0;
    if ((state_q == ST_RUN) && !Clear_SI && LoggerReady_SI && !LoggerFull_SI) begin
      // Walk from the farthest candidate back to the pointer so the closest wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = {1'b0, rr_q} + (SRC_BITW+1)'(k);
        if (cand >= (SRC_BITW+1)'(NUM_REQ)) begin
          cand = cand - (SRC_BITW+1)'(NUM_REQ);
        end else begin
          cand = cand;
        end
        if (!empty_s[cand[SRC_BITW-1:0]]) begin
          gnt_valid_s = 1'b1;
          gnt_idx_s   = cand[SRC_BITW-1:0];
        end else begin
          gnt_valid_s = gnt_valid_s;
        end
      end
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  // Pop/push/drop decisions; a pop in the same cycle frees the slot for a push.
  always_comb begin
    pop_s  = '0;
    push_s = '0;
    drop_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop_s[i] = gnt_valid_s && (gnt_idx_s == SRC_BITW'(i));
      if (accept_s && ReqEvent_SI[i]) begin
        if (!full_s[i] || pop_s[i]) begin
          push_s[i] = 1'b1;
        end else begin
          drop_s[i] = 1'b1;
        end
      end else begin
        push_s[i] = 1'b0;
      end
    end
  end

  // Next FIFO pointers, RR pointer and busy flag.
  always_comb begin
    rr_d   = rr_q;
    busy_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hold_clear_s) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_BITW'(push_s[i]);
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_BITW'(pop_s[i]);
      end
      busy_d = busy_d || (wr_ptr_d[i] != rd_ptr_d[i]);
    end
    if (hold_clear_s) begin
      rr_d = '0;
    end else if (gnt_valid_s) begin
      if (gnt_idx_s == SRC_BITW'(NUM_REQ - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = gnt_idx_s + SRC_BITW'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Output strobe/data for the logger and saturating drop bookkeeping.
  always_comb begin
    logic [16:0] cnt_sum;
    trig_d     = gnt_valid_s;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    cnt_sum    = {1'b0, drop_cnt_q} + 17'(popcount(drop_s));
    if (gnt_valid_s) begin
      data_d = {gnt_idx_s, fifo_mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s][IDX_BITW-1:0]]};
    end else begin
      data_d = data_q;
    end
    if (Clear_SI) begin
      drop_cnt_d = 16'd0;
      overflow_d = 1'b0;
    end else begin
      drop_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      overflow_d = overflow_q || (drop_s != '0);
    end
  end

  // Controller next state: clear has priority, HALT only leaves via clear.
  always_comb begin
    state_d = state_q;
    if (Clear_SI) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: state_d = LoggerReady_SI ? ST_RUN : ST_CLEAR;
        ST_RUN:   state_d = LoggerFull_SI ? ST_HALT : ST_RUN;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= ST_CLEAR;
      rr_q       <= '0;
      trig_q     <= 1'b0;
      data_q     <= '0;
      drop_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      trig_q     <= trig_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_s[i]) begin
        fifo_mem_q[i][wr_ptr_q[i][IDX_BITW-1:0]] <= ReqData_DI[i*REQ_DATA_BITW +: REQ_DATA_BITW];
      end
    end
  end

  assign LogTrigger_SO = trig_q;
  assign LogData_DO    = data_q;
  assign DropCnt_DO    = drop_cnt_q;
  assign Overflow_SO   = overflow_q;
  assign Busy_SO       = busy_q;

endmodule

// File: tb/tb_axi_log_arbiter.sv
// Self-checking bench for axi_log_arbiter: scoreboard of expected logger
// records, a table of overflow vectors and hand-written corner sequences.
module tb_axi_log_arbiter;
  localparam int NR = 4;
  localparam int DW = 48;
  localparam int OW = DW + 2;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  ev;
  logic [NR*DW-1:0] req_data;
  logic           en, clr, rdy, lfull;
  logic           trig;
  logic [OW-1:0]  ldata;
  logic [15:0]    dcnt;
  logic           ovf, busy;

  int total = 0;
  int bad = 0;
  int trig_cnt = 0;
  bit sb_on = 1'b1;
  logic [OW-1:0] exp_q[$];

  typedef struct {
    logic [NR-1:0] ev;
    logic          en;
    logic          push;
    logic [DW-1:0] pl;
    logic [15:0]   cnt;
    logic          ovf;
    logic          busy;
  } vec_t;
  vec_t tbl [7];

  axi_log_arbiter #(.NUM_REQ(NR), .REQ_DATA_BITW(DW), .FIFO_DEPTH(2)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .ReqEvent_SI(ev), .ReqData_DI(req_data),
    .LogEn_SI(en), .Clear_SI(clr), .LoggerReady_SI(rdy), .LoggerFull_SI(lfull),
    .LogTrigger_SO(trig), .LogData_DO(ldata), .DropCnt_DO(dcnt),
    .Overflow_SO(ovf), .Busy_SO(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every trigger pops and compares the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && trig) begin
      trig_cnt++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got trigger data %0h want no trigger", ldata);
        end else begin
          check("sb_data", 64'(ldata), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pl(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic expect_rec(input int src, input logic [DW-1:0] v);
    exp_q.push_back({2'(src), v});
  endtask

  task automatic fire(input logic [NR-1:0] mask, input logic e);
    ev = mask;
    en = e;
    cyc();
    ev = '0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_from_clear(input logic keep_rdy);
    rdy = 1'b1;
    cyc();
    rdy = keep_rdy;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trig"}, 64'(trig), 64'd0);
    check({tag, "_data"}, 64'(ldata), 64'd0);
    check({tag, "_dcnt"}, 64'(dcnt), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Fire all requesters at once; grants must run start, start+1, ... back to back.
  task automatic rr_burst(input int start);
    for (int i = 0; i < NR; i++) set_pl(i, 48'hA000_0000_0000 + 48'(start * 16 + i));
    for (int k = 0; k < NR; k++) begin
      int s;
      s = (start + k) % NR;
      expect_rec(s, 48'hA000_0000_0000 + 48'(start * 16 + s));
    end
    fire(4'b1111, 1'b1);
    for (int k = 0; k < NR; k++) begin
      cyc();
      check("rr_consecutive", 64'(trig), 64'd1);
    end
    cyc();
    check("rr_idle_after", 64'(trig), 64'd0);
  endtask

  initial begin
    int tc0;
    bit seen;
    logic [OW-1:0] held;
    rst_n = 1'b0; ev = '0; req_data = '0; en = 1'b1; clr = 1'b0; rdy = 1'b1; lfull = 1'b0;

    tbl[0] = '{4'b0010, 1'b1, 1'b1, 48'h1111_0000_0001, 16'd0, 1'b0, 1'b1};
    tbl[1] = '{4'b0010, 1'b1, 1'b1, 48'h1111_0000_0002, 16'd0, 1'b0, 1'b1};
    tbl[2] = '{4'b0010, 1'b0, 1'b0, 48'h1111_0000_0003, 16'd0, 1'b0, 1'b1};
    tbl[3] = '{4'b0010, 1'b1, 1'b0, 48'h1111_0000_0004, 16'd1, 1'b1, 1'b1};
    tbl[4] = '{4'b0010, 1'b1, 1'b0, 48'h1111_0000_0005, 16'd2, 1'b1, 1'b1};
    tbl[5] = '{4'b0010, 1'b1, 1'b0, 48'h1111_0000_0006, 16'd3, 1'b1, 1'b1};
    tbl[6] = '{4'b0000, 1'b1, 1'b0, 48'h0,              16'd3, 1'b1, 1'b1};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    cyc();                                  // CLEAR -> RUN, RR pointer 0

    // Single event on requester 2: trigger exactly two cycles after the event.
    set_pl(2, 48'h00AB_CDEF_0123);
    expect_rec(2, 48'h00AB_CDEF_0123);
    fire(4'b0100, 1'b1);
    check("single_t1_trig", 64'(trig), 64'd0);
    check("single_t1_busy", 64'(busy), 64'd1);
    cyc();
    check("single_t2_trig", 64'(trig), 64'd1);
    check("single_t2_data", 64'(ldata), 64'({2'd2, 48'h00AB_CDEF_0123}));
    check("single_t2_busy", 64'(busy), 64'd0);
    held = ldata;
    cyc();
    check("single_t3_trig", 64'(trig), 64'd0);
    check("single_hold_data", 64'(ldata), 64'(held));

    // Round-robin from pointer 0, then steer the pointer to 2.
    do_clear();
    run_from_clear(1'b1);
    rr_burst(0);
    set_pl(1, 48'h0000_0000_0B01);
    expect_rec(1, 48'h0000_0000_0B01);
    fire(4'b0010, 1'b1);
    repeat (3) cyc();
    rr_burst(2);

    // Overflow table with the logger not ready.
    do_clear();
    run_from_clear(1'b0);
    for (int v = 0; v < 7; v++) begin
      set_pl(1, tbl[v].pl);
      if (tbl[v].push) expect_rec(1, tbl[v].pl);
      fire(tbl[v].ev, tbl[v].en);
      check("ovf_dcnt", 64'(dcnt), 64'(tbl[v].cnt));
      check("ovf_flag", 64'(ovf), 64'(tbl[v].ovf));
      check("ovf_busy", 64'(busy), 64'(tbl[v].busy));
    end
    en = 1'b1;
    tc0 = trig_cnt;
    rdy = 1'b1;
    repeat (6) cyc();
    check("ovf_trig_count", 64'(trig_cnt - tc0), 64'd2);

    // Full FIFO popped and pushed in the same cycle: no drop.
    do_clear();
    run_from_clear(1'b0);
    set_pl(0, 48'hC0C0_0000_0001); expect_rec(0, 48'hC0C0_0000_0001); fire(4'b0001, 1'b1);
    set_pl(0, 48'hC0C0_0000_0002); expect_rec(0, 48'hC0C0_0000_0002); fire(4'b0001, 1'b1);
    tc0 = trig_cnt;
    rdy = 1'b1;
    set_pl(0, 48'hC0C0_0000_0003); expect_rec(0, 48'hC0C0_0000_0003); fire(4'b0001, 1'b1);
    check("pushpop_dcnt", 64'(dcnt), 64'd0);
    check("pushpop_ovf", 64'(ovf), 64'd0);
    check("pushpop_busy", 64'(busy), 64'd1);
    repeat (5) cyc();
    check("pushpop_trig_count", 64'(trig_cnt - tc0), 64'd3);
    check("pushpop_sb_left", 64'(exp_q.size()), 64'd0);

    // Logger full: HALT keeps entries, no triggers, exit only through clear.
    do_clear();
    run_from_clear(1'b0);
    for (int i = 0; i < 3; i++) set_pl(i, 48'hF00D_0000_0000 + 48'(i));
    fire(4'b0111, 1'b1);                    // queued but never expected at the logger
    lfull = 1'b1;
    cyc();                                  // RUN -> HALT
    lfull = 1'b0;
    rdy = 1'b1;
    tc0 = trig_cnt;
    repeat (3) cyc();
    check("halt_no_trig", 64'(trig_cnt - tc0), 64'd0);
    check("halt_busy", 64'(busy), 64'd1);
    fire(4'b0001, 1'b1);
    fire(4'b0001, 1'b1);
    check("halt_drop_dcnt", 64'(dcnt), 64'd1);
    check("halt_drop_ovf", 64'(ovf), 64'd1);
    rdy = 1'b0;
    do_clear();
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_dcnt", 64'(dcnt), 64'd0);
    check("clear_ovf", 64'(ovf), 64'd0);
    fire(4'b1000, 1'b1);                    // CLEAR without ready: ignored, not a drop
    cyc();
    check("clear_ignore_busy", 64'(busy), 64'd0);
    check("clear_ignore_dcnt", 64'(dcnt), 64'd0);
    run_from_clear(1'b1);
    set_pl(3, 48'h0000_3333_3333);
    expect_rec(3, 48'h0000_3333_3333);
    tc0 = trig_cnt;
    fire(4'b1000, 1'b1);
    repeat (3) cyc();
    check("after_clear_trig_count", 64'(trig_cnt - tc0), 64'd1);
    check("after_clear_sb_left", 64'(exp_q.size()), 64'd0);

    // Drop counter saturation, then asynchronous reset during a trigger.
    do_clear();
    run_from_clear(1'b0);
    sb_on = 1'b0;
    fire(4'b1111, 1'b1);
    fire(4'b1111, 1'b1);
    check("sat_fill_dcnt", 64'(dcnt), 64'd0);
    for (int n = 0; n < 16383; n++) fire(4'b1111, 1'b1);
    fire(4'b0011, 1'b1);
    check("sat_preload", 64'(dcnt), 64'hFFFE);
    fire(4'b1111, 1'b1);
    check("sat_cap", 64'(dcnt), 64'hFFFF);
    fire(4'b1111, 1'b1);
    check("sat_hold", 64'(dcnt), 64'hFFFF);
    check("sat_ovf", 64'(ovf), 64'd1);
    rdy = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      cyc();
      if (trig) seen = 1'b1;
    end
    check("reset_trig_seen", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    cyc();
    rst_n = 1'b1;
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_log_arbiter.md
# axi_log_arbiter

Shares one BRAM logger between several AXI address-channel monitors. Each requester reports completed AR/AW handshakes. The block buffers each event in a small per-requester FIFO and drains the FIFOs round-robin, at most one entry per cycle, into the logger's single trigger/data input. It also sequences logger clear/ready/full status and counts events lost to FIFO overflow. It sits between the per-channel handshake taps and the logger instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `REQ_DATA_BITW`, 48: payload width per requester (len/id/addr packed by the requester).
- `FIFO_DEPTH`, 2: entries per requester FIFO; power of two, >= 2.
- `SRC_BITW`, derived: `max(1, clog2(NUM_REQ))`. Do not override.
- `Clk_CI` in 1: single clock for all logic.
- `Rst_RBI` in 1: asynchronous, active-low reset.
- `ReqEvent_SI` in NUM_REQ: bit i = requester i completed a handshake this cycle (valid && ready).
- `ReqData_DI` in NUM_REQ*REQ_DATA_BITW: payload i is in bits `[i*REQ_DATA_BITW +: REQ_DATA_BITW]`; sampled when event bit i is set.
- `LogEn_SI` in 1: accept new events only while high.
- `Clear_SI` in 1: clears the arbiter and the logger (forwarded to the logger by the integrator).
- `LoggerReady_SI` in 1: logger Ready status.
- `LoggerFull_SI` in 1: logger Full status.
- `LogTrigger_SO` out 1: one-cycle log strobe to the logger.
- `LogData_DO` out REQ_DATA_BITW+SRC_BITW: `{source index, payload}`; payload in the low bits.
- `DropCnt_DO` out 16: saturating count of dropped events.
- `Overflow_SO` out 1: sticky; set on the first drop.
- `Busy_SO` out 1: high while any FIFO is non-empty.

## Operation
- FSM states are CLEAR, RUN and HALT. Reset enters CLEAR.
- **CLEAR**
  - FIFOs are held empty and the RR pointer is 0.
  - Events are ignored and are not counted as drops.
  - Exit to RUN when `LoggerReady_SI`=1 and `Clear_SI`=0.
- **RUN**
  - Push: event i with `LogEn_SI`=1 is pushed if FIFO i is not full. If full, it is dropped.
  - Drain: grant when any FIFO is non-empty, `LoggerReady_SI`=1 and `LoggerFull_SI`=0.
  - If `LoggerFull_SI` rises, go to HALT.
- **HALT**
  - No draining. FIFOs keep their contents.
  - Pushes continue under the same full/drop rule.
  - Exit is only through `Clear_SI`.
- `Clear_SI`=1 in any state moves to CLEAR on the next edge. It also zeros `DropCnt_DO` and `Overflow_SO` and empties all FIFOs (contents discarded, not counted).
- **Arbitration**
  - Round-robin over non-empty FIFOs.
  - Search starts at the RR pointer. After granting index g, the pointer becomes (g+1) mod NUM_REQ.
  - The pointer does not move when nothing is granted.
- **Drop counting**
  - Each cycle, add the popcount of dropped event bits to `DropCnt_DO`, saturating at 0xFFFF.
  - Set `Overflow_SO` if the popcount is > 0.
  - Events with `LogEn_SI`=0 are not drops.
- **Push and pop on the same FIFO in one cycle:** the pop frees a slot first, so a push to a full FIFO that is also being popped is accepted. Occupancy is unchanged.
- FIFO pointers carry one extra wrap bit for the full/empty distinction. Read and write indices wrap modulo FIFO_DEPTH.
- Logger timestamps mark drain time, not handshake time. The skew is bounded by queueing delay and is documented to users.

## Timing
- Reset values:
  - `LogTrigger_SO`=0, `LogData_DO`=0, `DropCnt_DO`=0, `Overflow_SO`=0, `Busy_SO`=0.
  - FSM=CLEAR, RR pointer=0.
- `LogTrigger_SO` and `LogData_DO` are registered. A grant decided in cycle t produces the trigger and data in cycle t+1. `LogData_DO` holds its value when the trigger is low.
- Minimum latency: an event in cycle t into an empty FIFO is granted in t+1, and the trigger is high in t+2.
- Aggregate throughput is one entry per cycle. Each requester is served at least once every NUM_REQ grants while non-empty.
- Full/ready gating applies to the grant decision only. A trigger already registered is still emitted the cycle after `LoggerFull_SI` rises; the logger discards it.
- `Busy_SO`, `DropCnt_DO` and `Overflow_SO` update one cycle after the causing edge (registered).
- Asynchronous reset mid-operation clears everything immediately, including a trigger in flight.

## Test plan
- **Single event:** after CLEAR→RUN, one event on requester 2 with payload 0x00AB_CDEF_0123 → `LogTrigger_SO` pulses exactly 2 cycles later. `LogData_DO` = {2, 0x00AB_CDEF_0123}.
- **Round-robin:** all 4 requesters fire in the same cycle, RR pointer 0 → 4 consecutive triggers with sources 0,1,2,3. Repeat with pointer 2 → order 2,3,0,1.
- **Overflow:**
  - FIFO_DEPTH=2, `LoggerReady_SI`=0 forced after entering RUN.
  - 5 events on requester 1 → 2 stored, `DropCnt_DO`=3, `Overflow_SO`=1.
  - Release ready → exactly 2 triggers.
- **Full-FIFO push/pop:** requester 0 FIFO full and being granted while a new event arrives → no drop, occupancy stays 2.
- **Logger full:** `LoggerFull_SI` asserted with 3 queued entries → FSM enters HALT, no further triggers, `Busy_SO`=1. Then `Clear_SI` → FIFOs empty, `DropCnt_DO`=0, `Overflow_SO`=0, CLEAR until `LoggerReady_SI`=1.
- **Saturation and reset:**
  - Preload 0xFFFE drops, then drop 4 events in one cycle → `DropCnt_DO`=0xFFFF.
  - Assert `Rst_RBI`=0 mid-trigger → all outputs 0 immediately.
